pc_unit_ras: RTL

//  Parametrised next-generation program counter for the IITB CPU fetch stage.

---
 rtl/pc_pkg.sv | 14 +
 rtl/ras_stack.sv | 70 +++++++
 rtl/pc_unit_ras.sv | 105 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter.
//   PC_OP_W       : width of the pc_op select bus
//   PC_OP_*       : operation encodings driven by the control FSM
package pc_pkg;

  localparam int PC_OP_W = 3;

  localparam logic [PC_OP_W-1:0] PC_OP_INC    = 3'b000;
  localparam logic [PC_OP_W-1:0] PC_OP_BRANCH = 3'b001;
  localparam logic [PC_OP_W-1:0] PC_OP_JUMP   = 3'b010;
  localparam logic [PC_OP_W-1:0] PC_OP_CALL   = 3'b011;
  localparam logic [PC_OP_W-1:0] PC_OP_RET    = 3'b100;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack.
//   clk, rst_n : clock, asynchronous active-low reset (pointer and count only)
//   push       : write push_data at the top; on full the oldest entry is lost
//   pop        : discard the top entry (caller must not pop when empty)
//   push_data  : return address to store
//   top        : most recently pushed valid entry
//   count      : number of valid entries, saturates at RAS_DEPTH
module ras_stack #(
  parameter int ADDR_W    = 6,
  parameter int RAS_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic                             pop,
  input  logic [ADDR_W-1:0]                push_data,
  output logic [ADDR_W-1:0]                top,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [ADDR_W-1:0] mem_d [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;     // next slot to write
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  ptr_next, ptr_prev;

  // Explicit wrap so non-power-of-two depths stay in range.
  assign ptr_next = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
  assign ptr_prev = (ptr_q == '0) ? PTR_LAST : ptr_q - 1'b1;

  assign top   = mem_q[ptr_prev];
  assign count = count_q;

  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      // Writing over the slot of the oldest entry when full keeps the
      // newest RAS_DEPTH addresses, which is what deep call chains want.
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_next;
      if (count_q != CNT_FULL) count_d = count_q + 1'b1;
    end else if (pop && (count_q != '0)) begin
      ptr_d   = ptr_prev;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Stack contents are don't-care after reset, so they carry no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_unit_ras.sv
// Parametrised fetch-stage program counter with return-address stack.
//   clk, rst_n   : clock, asynchronous active-low reset
//   pc_write_en  : 1 = perform pc_op this cycle, 0 = hold
//   pc_op        : INC / BRANCH / JUMP / CALL / RET (see pc_pkg)
//   offset_val   : two's-complement branch offset
//   target_addr  : absolute target for JUMP / CALL
//   err_clr      : clears sticky ras_ovf / ras_unf
//   pc_out       : registered current PC
//   ras_count    : valid RAS entries; ras_full / ras_empty decoded from it
//   ras_ovf      : sticky, CALL issued while RAS full
//   ras_unf      : sticky, RET issued while RAS empty
module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = 6,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           pc_write_en,
  input  logic [PC_OP_W-1:0]             pc_op,
  input  logic [ADDR_W-1:0]              offset_val,
  input  logic [ADDR_W-1:0]              target_addr,
  input  logic                           err_clr,
  output logic [ADDR_W-1:0]              pc_out,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_full,
  output logic                           ras_empty,
  output logic                           ras_ovf,
  output logic                           ras_unf
);

  localparam int CNT_W = $clog2(RAS_DEPTH+1);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, ras_top;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              push, pop;

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .count     (ras_count)
  );

  assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
  assign ras_empty = (ras_count == '0);
  assign pc_inc    = pc_q + ADDR_W'(1);

  always_comb begin
    pc_d  = pc_q;
    push  = 1'b0;
    pop   = 1'b0;
    // Clear first; a flag raised by this cycle's op below overrides it.
    ovf_d = err_clr ? 1'b0 : ovf_q;
    unf_d = err_clr ? 1'b0 : unf_q;
    if (pc_write_en) begin
      unique case (pc_op)
        PC_OP_INC:    pc_d = pc_inc;
        // Same-width modular add equals adding the sign-extended offset.
        PC_OP_BRANCH: pc_d = pc_inc + offset_val;
        PC_OP_JUMP:   pc_d = target_addr;
        PC_OP_CALL: begin
          push = 1'b1;
          pc_d = target_addr;
          if (ras_full) ovf_d = 1'b1;
        end
        PC_OP_RET: begin
          if (ras_empty) begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = ras_top;
          end
        end
        default: ;  // reserved encodings hold all state
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc_out  = pc_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;

endmodule
